kvt_proj_name_rst_seq: RTL and testbench
========================================

# kvt_proj_name_rst_seq

Reset and clock-enable sequencer for the proj_name DUT. It owns the environment's single clock and reset and turns them into a staged per-domain reset release with a leading clock-gate window. It sits between the top-level clock/reset and the DUT sub-domains. Software can re-run the sequence at any time without a hardware reset.

## Interface
- N_DOMAINS, 4, number of reset domains, released in index order 0..N-1 (1..16)
- CNT_W, 8, width of each per-domain release delay
- GATE_CYC, 2, cycles clk_en_o stays low after hardware reset (≥1)
- ASSERT_CYC, 4, cycles all resets are held with the clock enabled (≥1)

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- sw_rst_req  in  1  synchronous software restart request, sampled every cycle
- dly_cfg  in  N_DOMAINS*CNT_W  per-domain release delay; slice k = dly_cfg[k*CNT_W +: CNT_W]
- dom_rst_o  out  N_DOMAINS  per-domain reset, active-high, registered
- clk_en_o  out  1  enable for the DUT clock gate, registered
- done_o  out  1  high once all domains are released
- busy_o  out  1  equals !done_o

## Operation
- States: GATE, ASSERT, RELEASE, DONE. One stage counter (CNT_W+1 bits) and a domain index, idx.
- While rst is high: state=GATE, counter=0, idx=0, dom_rst_o=all 1, clk_en_o=0, done_o=0, busy_o=1.
- GATE: clk_en_o=0 and all resets asserted. After GATE_CYC cycles, go to ASSERT.
- On entry to ASSERT, dly_cfg is latched into a shadow register. Later dly_cfg changes have no effect until the next ASSERT entry.
- ASSERT: clk_en_o=1 and all resets asserted. After ASSERT_CYC cycles, go to RELEASE with idx=0.
- RELEASE: stage k lasts shadow_dly[k]+1 cycles. At the end of stage k, dom_rst_o[k] clears, the counter clears and idx increments. A delay of 0 releases the domain after 1 cycle.
- The edge that clears dom_rst_o[N-1] also sets done_o and moves the FSM to DONE.
- DONE: holds all outputs. clk_en_o=1, dom_rst_o=0.
- sw_rst_req=1 in any state:
  - Next edge: state=ASSERT, dom_rst_o=all 1, counter=0, idx=0, done_o=0, clk_en_o=1.
  - GATE is skipped.
  - sw_rst_req held high keeps the block in ASSERT with the counter at 0.
  - sw_rst_req has priority over every other transition in the same cycle.
- rst asserted mid-sequence forces the reset values immediately (asynchronous). On rst deassertion the sequence restarts from GATE.
- Domains never release out of order. A released domain never re-asserts except via sw_rst_req or rst.

## Timing
- Cycle 1 is the first rising edge with rst low.
- clk_en_o rises at edge GATE_CYC+1.
- Domain k deasserts at edge GATE_CYC + ASSERT_CYC + Σ_{j≤k}(dly[j]+1).
- After sw_rst_req is sampled high at edge E (and then low), domain k deasserts at E + ASSERT_CYC + Σ_{j≤k}(dly[j]+1).
- All outputs come straight from flops. There are no combinational paths from inputs to outputs.

## Structure
- Package kvt_proj_name_rst_pkg holds:
  - the state enum (GATE, ASSERT, RELEASE, DONE)
  - the default constants for GATE_CYC, ASSERT_CYC and CNT_W
- Sub-module kvt_proj_name_stage_timer: a loadable up-counter with clear and a terminal-count flag. One instance is shared across all states.
- The FSM, shadow register and output flops live in the top module.

## Test plan
- Power-on, N=4, GATE=2, ASSERT=4, dly={0,3,1,2} → clk_en_o rises at edge 3; dom_rst_o bits fall at edges 7, 11, 13, 16; done_o rises at edge 16.
- All dly=0 → domains release on consecutive edges 7, 8, 9, 10; done_o rises at edge 10.
- In DONE, 1-cycle sw_rst_req at edge E → dom_rst_o=4'hF at E; clk_en_o stays 1; domains release at E+5, E+9, E+11, E+14.
- sw_rst_req after domain 1 releases (mid-RELEASE) → all resets re-assert the next edge and the sequence restarts from ASSERT; no domain releases out of order.
- dly_cfg changed to all-0xFF during RELEASE → no change in release timing; the new values apply only after the next sw_rst_req.
- rst pulsed mid-ASSERT and mid-RELEASE → outputs take reset values with no clock edge needed; after rst deasserts, the full GATE sequence timing matches the first scenario.

Source files
------------

// File: rtl/kvt_proj_name_rst_pkg.sv
// Shared types and default timing constants for the proj_name reset sequencer.
// State encoding is private to the sequencer; outputs never expose it.
package kvt_proj_name_rst_pkg;

    localparam int DEF_N_DOMAINS  = 4;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_GATE_CYC   = 2;
    localparam int DEF_ASSERT_CYC = 4;

    typedef enum logic [1:0] {
        S_GATE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_RELEASE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/kvt_proj_name_stage_timer.sv
// Stage timer: up-counter with clear/load/enable and a terminal-count flag against a live limit.
// Latency: tc_o is combinational from the counter flop; clear has priority over load over count.
module kvt_proj_name_stage_timer #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/kvt_proj_name_rst_seq.sv
// Staged reset/clock-enable sequencer: clock-gate window, common assert window, then in-order domain release.
// Latency: all outputs registered; sw_rst_req acts on the next edge and overrides every other transition.
module kvt_proj_name_rst_seq
    import kvt_proj_name_rst_pkg::*;
#(
    parameter int N_DOMAINS  = DEF_N_DOMAINS,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GATE_CYC   = DEF_GATE_CYC,
    parameter int ASSERT_CYC = DEF_ASSERT_CYC
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sw_rst_req,
    input  logic [N_DOMAINS*CNT_W-1:0]   dly_cfg,
    output logic [N_DOMAINS-1:0]         dom_rst_o,
    output logic                         clk_en_o,
    output logic                         done_o,
    output logic                         busy_o
);

    localparam int TW    = CNT_W + 1;
    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    localparam logic [TW-1:0]    GATE_LIM   = TW'(GATE_CYC);
    localparam logic [TW-1:0]    ASSERT_LIM = TW'(ASSERT_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DOMAINS - 1);
    // The GATE-exit edge already counts as the first assert cycle after power-on,
    // so a one-cycle assert window collapses to nothing on that path.
    localparam bit               POR_SKIP_ASSERT = (ASSERT_CYC == 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [N_DOMAINS-1:0]   dom_rst_q, dom_rst_d;
    logic                   clk_en_q, clk_en_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       shadow_q [N_DOMAINS];

    logic                   shadow_ld;
    logic                   tmr_clr;
    logic                   tmr_load;
    logic                   tmr_en;
    logic [TW-1:0]          tmr_lim;
    logic                   tmr_tc;

    kvt_proj_name_stage_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (TW'(1)),
        .en_i       (tmr_en),
        .limit_i    (tmr_lim),
        .tc_o       (tmr_tc)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dom_rst_d = dom_rst_q;
        clk_en_d  = clk_en_q;
        done_d    = done_q;
        shadow_ld = 1'b0;
        tmr_clr   = 1'b0;
        tmr_load  = 1'b0;
        tmr_en    = 1'b1;
        tmr_lim   = '0;

        case (state_q)
            S_GATE:    tmr_lim = GATE_LIM;
            S_ASSERT:  tmr_lim = ASSERT_LIM;
            S_RELEASE: tmr_lim = {1'b0, shadow_q[idx_q]};
            default:   tmr_lim = '0;
        endcase

        if (sw_rst_req) begin
            state_d   = S_ASSERT;
            idx_d     = '0;
            dom_rst_d = '1;
            clk_en_d  = 1'b1;
            done_d    = 1'b0;
            shadow_ld = 1'b1;
            tmr_clr   = 1'b1;
        end else begin
            case (state_q)
                S_GATE: begin
                    clk_en_d = 1'b0;
                    if (tmr_tc) begin
                        clk_en_d  = 1'b1;
                        shadow_ld = 1'b1;
                        idx_d     = '0;
                        if (POR_SKIP_ASSERT) begin
                            state_d = S_RELEASE;
                            tmr_clr = 1'b1;
                        end else begin
                            state_d  = S_ASSERT;
                            tmr_load = 1'b1;
                        end
                    end
                end
                S_ASSERT: begin
                    if (tmr_tc) begin
                        state_d = S_RELEASE;
                        idx_d   = '0;
                        tmr_clr = 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (tmr_tc) begin
                        dom_rst_d[idx_q] = 1'b0;
                        tmr_clr          = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    tmr_en = 1'b0;
                end
            endcase
        end

        busy_d = ~done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_GATE;
            idx_q     <= '0;
            dom_rst_q <= '1;
            clk_en_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dom_rst_q <= dom_rst_d;
            clk_en_q  <= clk_en_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // Release delays are frozen at assert entry so software can stage the next config early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_DOMAINS; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (shadow_ld) begin
            for (int k = 0; k < N_DOMAINS; k++) begin
                shadow_q[k] <= dly_cfg[k*CNT_W +: CNT_W];
            end
        end
    end

    assign dom_rst_o = dom_rst_q;
    assign clk_en_o  = clk_en_q;
    assign done_o    = done_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_kvt_proj_name_rst_seq.sv
// Bench for the reset sequencer: release edges predicted from the edge-number formulas.
// Per-cycle comparison of all outputs plus fixed-edge checks for the documented scenarios.
module tb_kvt_proj_name_rst_seq;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int GC = 2;
    localparam int AC = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           sw_rst_req = 1'b0;
    logic [N*W-1:0] dly_cfg = '0;
    logic [N-1:0]   dom_rst_o;
    logic           clk_en_o;
    logic           done_o;
    logic           busy_o;
    logic [N+2:0]   obs;

    int checks = 0;
    int errors = 0;

    // Model: edges counted from 1 after reset release (or from a sw request edge).
    int cyc  = 0;
    int base = GC;
    bit pwr  = 1'b1;
    int mdly [N];

    kvt_proj_name_rst_seq #(
        .N_DOMAINS  (N),
        .CNT_W      (W),
        .GATE_CYC   (GC),
        .ASSERT_CYC (AC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .dly_cfg    (dly_cfg),
        .dom_rst_o  (dom_rst_o),
        .clk_en_o   (clk_en_o),
        .done_o     (done_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    assign obs = {dom_rst_o, clk_en_o, done_o, busy_o};

    function automatic logic [N+2:0] exp_out();
        int r;
        logic [N-1:0] d;
        logic ce;
        logic dn;
        r = base + AC;
        for (int k = 0; k < N; k++) begin
            r += mdly[k] + 1;
            d[k] = (cyc < r);
        end
        dn = (cyc >= r);
        ce = pwr ? (cyc >= GC + 1) : 1'b1;
        return {d, ce, dn, ~dn};
    endfunction

    task automatic step();
        logic           s;
        logic [N*W-1:0] c;
        s = sw_rst_req;
        c = dly_cfg;
        @(posedge clk);
        cyc++;
        if (s || (pwr && cyc == GC + 1)) begin
            if (s) begin
                base = cyc;
                pwr  = 1'b0;
            end
            for (int k = 0; k < N; k++) mdly[k] = int'(c[k*W +: W]);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (obs !== {{N{1'b1}}, 3'b001}) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", obs, {{N{1'b1}}, 3'b001});
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== {{N{1'b1}}, 3'b001}) begin
            errors++;
            $display("FAIL reset_held got=%b exp=%b", obs, {{N{1'b1}}, 3'b001});
        end
        rst  = 1'b0;
        cyc  = 0;
        base = GC;
        pwr  = 1'b1;
    endtask

    task automatic test_power_on(string tag);
        int exp_fall [N];
        int fall [N];
        int ce_rise;
        logic [N-1:0] prev;
        logic pce;
        exp_fall = '{7, 11, 13, 16};
        for (int k = 0; k < N; k++) fall[k] = -1;
        ce_rise = -1;
        prev = dom_rst_o;
        pce = clk_en_o;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL %s edge=%0d got=%b exp=%b", tag, cyc, obs, exp_out());
            end
            for (int k = 0; k < N; k++) if (prev[k] && !dom_rst_o[k]) fall[k] = cyc;
            if (!pce && clk_en_o) ce_rise = cyc;
            prev = dom_rst_o;
            pce = clk_en_o;
        end
        checks++;
        if (ce_rise != 3) begin
            errors++;
            $display("FAIL %s_clk_en_rise got=%0d exp=3", tag, ce_rise);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (fall[k] != exp_fall[k]) begin
                errors++;
                $display("FAIL %s_fall%0d got=%0d exp=%0d", tag, k, fall[k], exp_fall[k]);
            end
        end
    endtask

    task automatic test_all_zero();
        dly_cfg = '0;
        test_reset();
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL all_zero edge=%0d got=%b exp=%b", cyc, obs, exp_out());
            end
        end
        checks++;
        if (dom_rst_o !== '0 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL all_zero_done got=%b/%b exp=0000/1", dom_rst_o, done_o);
        end
    endtask

    task automatic test_sw_in_done();
        int exp_off [N];
        int fall [N];
        int e;
        logic [N-1:0] prev;
        exp_off = '{5, 9, 11, 14};
        for (int k = 0; k < N; k++) fall[k] = -1;
        dly_cfg = {8'd2, 8'd1, 8'd3, 8'd0};
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        e = cyc;
        checks++;
        if (obs !== {{N{1'b1}}, 3'b101}) begin
            errors++;
            $display("FAIL sw_done_assert got=%b exp=%b", obs, {{N{1'b1}}, 3'b101});
        end
        prev = dom_rst_o;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL sw_done edge=%0d got=%b exp=%b", cyc, obs, exp_out());
            end
            for (int k = 0; k < N; k++) if (prev[k] && !dom_rst_o[k]) fall[k] = cyc - e;
            prev = dom_rst_o;
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (fall[k] != exp_off[k]) begin
                errors++;
                $display("FAIL sw_done_fall%0d got=E+%0d exp=E+%0d", k, fall[k], exp_off[k]);
            end
        end
    endtask

    task automatic test_sw_mid_release();
        for (int k = 0; k < N; k++) dly_cfg[k*W +: W] = W'($urandom_range(0, 5));
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        for (int i = 0; i < 60 && dom_rst_o[1] === 1'b1; i++) begin
            step();
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL mid_rel_pre edge=%0d got=%b exp=%b", cyc, obs, exp_out());
            end
        end
        checks++;
        if (dom_rst_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_rel_timeout dom1 got=%b exp=0", dom_rst_o[1]);
        end
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        checks++;
        if (obs !== {{N{1'b1}}, 3'b101}) begin
            errors++;
            $display("FAIL mid_rel_reassert got=%b exp=%b", obs, {{N{1'b1}}, 3'b101});
        end
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL mid_rel edge=%0d got=%b exp=%b", cyc, obs, exp_out());
            end
        end
    endtask

    task automatic test_cfg_change();
        for (int k = 0; k < N; k++) dly_cfg[k*W +: W] = W'($urandom_range(1, 4));
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 6) dly_cfg = '1;
            step();
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL cfg_frozen edge=%0d got=%b exp=%b", cyc, obs, exp_out());
            end
        end
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        for (int i = 0; i < 4 * 256 + 12; i++) begin
            step();
            checks++;
            if (obs !== exp_out()) begin
                errors++;
                $display("FAIL cfg_applied edge=%0d got=%b exp=%b", cyc, obs, exp_out());
            end
        end
    endtask

    task automatic test_rst_mid();
        dly_cfg = {8'd2, 8'd1, 8'd3, 8'd0};
        test_reset();
        for (int i = 0; i < 4; i++) step();
        test_reset();
        for (int i = 0; i < 8; i++) step();
        test_reset();
        test_power_on("rst_mid");
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int hold;
            int run;
            for (int k = 0; k < N; k++) dly_cfg[k*W +: W] = W'($urandom_range(0, 7));
            hold = $urandom_range(1, 3);
            run  = $urandom_range(0, 45);
            sw_rst_req = 1'b1;
            for (int h = 0; h < hold; h++) begin
                step();
                checks++;
                if (obs !== exp_out()) begin
                    errors++;
                    $display("FAIL random_hold it=%0d edge=%0d got=%b exp=%b", it, cyc, obs, exp_out());
                end
            end
            sw_rst_req = 1'b0;
            for (int i = 0; i < run; i++) begin
                if (i == run / 2) dly_cfg = W'($urandom) * {N{8'h01}};
                step();
                checks++;
                if (obs !== exp_out()) begin
                    errors++;
                    $display("FAIL random it=%0d edge=%0d got=%b exp=%b", it, cyc, obs, exp_out());
                end
            end
        end
    endtask

    initial begin
        #1;
        dly_cfg = {8'd2, 8'd1, 8'd3, 8'd0};
        test_reset();
        test_power_on("power_on");
        test_all_zero();
        test_sw_in_done();
        test_sw_mid_release();
        test_cfg_change();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
